// File: rtl/seg7_scan_controller_pkg.sv
// Shared 7-segment encoding for display clients.
// Segment byte order: bit7 = a, bit6 = b, ... bit1 = g, bit0 = h (dp); all active-low.
package seg7_scan_controller_pkg;

   localparam logic [7:0] SEG_BLANK = 8'hFF;

   localparam int SEG_BIT_A  = 7;
   localparam int SEG_BIT_B  = 6;
   localparam int SEG_BIT_C  = 5;
   localparam int SEG_BIT_D  = 4;
   localparam int SEG_BIT_E  = 3;
   localparam int SEG_BIT_F  = 2;
   localparam int SEG_BIT_G  = 1;
   localparam int SEG_BIT_DP = 0;

   // Active-low abcdefg patterns, indexed by hex nibble value.
   localparam logic [15:0][6:0] SEG_HEX = {
      7'b0111000,  // F
      7'b0110000,  // E
      7'b1000010,  // d
      7'b0110001,  // C
      7'b1100000,  // b
      7'b0001000,  // A
      7'b0000100,  // 9
      7'b0000000,  // 8
      7'b0001111,  // 7
      7'b0100000,  // 6
      7'b0100100,  // 5
      7'b1001100,  // 4
      7'b0000110,  // 3
      7'b0010010,  // 2
      7'b1001111,  // 1
      7'b0000001   // 0
   };

   // Build the full segment byte from a pattern and a lit-high decimal point.
   function automatic logic [7:0] seg_pack(input logic [6:0] abcdefg, input logic dp_lit);
      return {abcdefg, ~dp_lit};
   endfunction

endpackage

// File: rtl/seg7_scan_controller_if.sv
// Producer-side valid/ready bus carrying new display contents.
interface seg7_scan_controller_if #(
   parameter int N_DIGITS = 8
);
   logic                  in_valid;
   logic                  in_ready;
   logic [4*N_DIGITS-1:0] in_value;
   logic [N_DIGITS-1:0]   in_dots;
   logic [N_DIGITS-1:0]   in_enable;

   modport master (
      output in_valid, in_value, in_dots, in_enable,
      input  in_ready
   );

   modport slave (
      input  in_valid, in_value, in_dots, in_enable,
      output in_ready
   );
endinterface

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-low abcdefg pattern.
module seg7_hex_decode
   import seg7_scan_controller_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg
);

   // Table lookup into the shared pattern set.
   assign seg = SEG_HEX[nibble];

endmodule

// File: rtl/seg7_scan_controller.sv
// Time-multiplexed 8-digit common-anode 7-segment scanner with a
// double-buffered input: new contents are staged through valid/ready and
// only copied to the display registers at the frame boundary.
// Optional build macro: SEG7_LEADING_ZERO_BLANK_EN (blank leading zeros at commit).
module seg7_scan_controller
   import seg7_scan_controller_pkg::*;
#(
   parameter int N_DIGITS     = 8,
   parameter int SCAN_DIV     = 50000,
   parameter int BLANK_CYCLES = 500
) (
   input  logic                  clk,
   input  logic                  rst_n,
   seg7_scan_controller_if.slave in_if,
   output logic [7:0]            abcdefgh,
   output logic [N_DIGITS-1:0]   digit,
   output logic                  frame_start
);

   localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

   localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCAN_DIV - 1);
   localparam logic [DIV_W-1:0] BLANK_END = DIV_W'(BLANK_CYCLES);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_DIGITS - 1);

   logic [DIV_W-1:0]               div_cnt;
   logic [IDX_W-1:0]               idx;
   logic                           pending;

   logic [N_DIGITS-1:0][3:0]       stg_value;
   logic [N_DIGITS-1:0]            stg_dots;
   logic [N_DIGITS-1:0]            stg_enable;

   logic [N_DIGITS-1:0][3:0]       dsp_value;
   logic [N_DIGITS-1:0]            dsp_dots;
   logic [N_DIGITS-1:0]            dsp_enable;

   logic                           tick;
   logic                           boundary;
   logic                           accept;
   logic [N_DIGITS-1:0]            eff_enable;
   logic [3:0]                     cur_nibble;
   logic [6:0]                     cur_seg;
   logic                           digit_on;
   logic [N_DIGITS-1:0]            sel_oh;

   assign tick     = (div_cnt == DIV_LAST);
   assign boundary = tick && (idx == IDX_LAST);
   assign accept   = in_if.in_valid && !pending;

   assign in_if.in_ready = ~pending;

`ifdef SEG7_LEADING_ZERO_BLANK_EN
   logic [N_DIGITS-1:0] lz_keep;
   logic                lz_seen;

   // A digit stays shown if it or any higher digit has a nonzero nibble or a lit dot.
   always_comb begin
      lz_keep = '0;
      lz_seen = 1'b0;
      for (int i = N_DIGITS - 1; i >= 0; i--) begin
         lz_seen    = lz_seen | (|stg_value[i]) | stg_dots[i];
         lz_keep[i] = lz_seen;
      end
      lz_keep[0] = 1'b1;
   end

   assign eff_enable = stg_enable & lz_keep;
`else
   assign eff_enable = stg_enable;
`endif

   // Slot timer and digit index; the N_DIGITS-1 -> 0 wrap is the frame boundary.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt <= '0;
         idx     <= '0;
      end else if (tick) begin
         div_cnt <= '0;
         idx     <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
      end else begin
         div_cnt <= div_cnt + DIV_W'(1);
      end
   end

   // Staging buffer fill on handshake, commit to display only at the frame boundary.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending    <= 1'b0;
         stg_value  <= '0;
         stg_dots   <= '0;
         stg_enable <= '0;
         dsp_value  <= '0;
         dsp_dots   <= '0;
         dsp_enable <= '0;
      end else begin
         if (accept) begin
            stg_value  <= in_if.in_value;
            stg_dots   <= in_if.in_dots;
            stg_enable <= in_if.in_enable;
         end
         // A commit always uses what was staged before this edge, so an accept
         // landing on the boundary waits a full frame rather than bypassing.
         if (boundary && pending) begin
            dsp_value  <= stg_value;
            dsp_dots   <= stg_dots;
            dsp_enable <= eff_enable;
            pending    <= 1'b0;
         end else if (accept) begin
            pending    <= 1'b1;
         end
      end
   end

   assign cur_nibble = dsp_value[idx];
   assign digit_on   = (div_cnt >= BLANK_END) && dsp_enable[idx];

   // One-hot select of the digit currently being scanned.
   always_comb begin
      sel_oh      = '0;
      sel_oh[idx] = 1'b1;
   end

   seg7_hex_decode u_hex_decode (
      .nibble (cur_nibble),
      .seg    (cur_seg)
   );

   // Registered pin drive, one cycle behind the slot timer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         abcdefgh    <= SEG_BLANK;
         digit       <= '1;
         frame_start <= 1'b0;
      end else begin
         frame_start <= boundary;
         if (digit_on) begin
            abcdefgh <= seg_pack(cur_seg, dsp_dots[idx]);
            digit    <= ~sel_oh;
         end else begin
            abcdefgh <= SEG_BLANK;
            digit    <= '1;
         end
      end
   end

endmodule

// File: tb/tb_seg7_scan_controller.sv
// Directed bench for seg7_scan_controller with SCAN_DIV=8, BLANK_CYCLES=2
// (64-cycle frames). Expected segment tables are hand-computed per digit.
module tb_seg7_scan_controller;

   logic       clk;
   logic       rst_n;
   logic [7:0] abcdefgh;
   logic [7:0] digit;
   logic       frame_start;
   int         cyc = 0;
   int         checks = 0;
   int         errors = 0;

   seg7_scan_controller_if #(.N_DIGITS(8)) in_if ();

   seg7_scan_controller #(
      .N_DIGITS     (8),
      .SCAN_DIV     (8),
      .BLANK_CYCLES (2)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_if       (in_if.slave),
      .abcdefgh    (abcdefgh),
      .digit       (digit),
      .frame_start (frame_start)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Clock count since reset release: at each negedge cyc equals the DUT state index.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   localparam logic [7:0][7:0] T_DARK  = {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
   localparam logic [7:0][7:0] T_FIRST = {8'h03, 8'h9F, 8'h25, 8'h0D, 8'h01, 8'h09, 8'h11, 8'h70};
   localparam logic [7:0][7:0] T_A     = {8'h1F, 8'h41, 8'h49, 8'h99, 8'h0D, 8'h25, 8'h9F, 8'h03};
   localparam logic [7:0][7:0] T_B     = {8'h63, 8'hFF, 8'h85, 8'hFF, 8'hC1, 8'hFF, 8'h61, 8'hFF};
   localparam logic [7:0][7:0] T_C     = {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h49};
`ifdef SEG7_LEADING_ZERO_BLANK_EN
   localparam logic [7:0][7:0] T_D     = {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h49, 8'h03};
   localparam logic [7:0][7:0] T_E     = {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h03};
   localparam logic [7:0][7:0] T_F     = {8'hFF, 8'hFF, 8'hFF, 8'h02, 8'h03, 8'h03, 8'h49, 8'h03};
`else
   localparam logic [7:0][7:0] T_D     = {8'h03, 8'h03, 8'h03, 8'h03, 8'h03, 8'h03, 8'h49, 8'h03};
   localparam logic [7:0][7:0] T_E     = {8'h03, 8'h03, 8'h03, 8'h03, 8'h03, 8'h03, 8'h03, 8'h03};
   localparam logic [7:0][7:0] T_F     = {8'h03, 8'h03, 8'h03, 8'h02, 8'h03, 8'h03, 8'h49, 8'h03};
`endif

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s obs=%h exp=%h (t=%0t cyc=%0d)", tag, obs, exp, $time, cyc);
      end
   endtask

   task automatic wait_to(input int t);
      int n;
      n = 0;
      while (cyc < t && n < 5000) begin
         @(negedge clk);
         n++;
      end
      if (cyc != t) check("wait_to", 32'(cyc), 32'(t));
   endtask

   // Offer one transfer; acc returns the state index in which it was accepted.
   task automatic send(input logic [31:0] v, input logic [7:0] d, input logic [7:0] e,
                       output int acc);
      int n;
      in_if.in_valid  = 1'b1;
      in_if.in_value  = v;
      in_if.in_dots   = d;
      in_if.in_enable = e;
      n = 0;
      while (!in_if.in_ready && n < 1000) begin
         @(negedge clk);
         n++;
      end
      if (!in_if.in_ready) check("send_timeout", 32'(in_if.in_ready), 32'd1);
      acc = cyc;
      @(negedge clk);
      in_if.in_valid = 1'b0;
   endtask

   // Check every cycle of the frame whose first state index is f.
   task automatic scan_frame(input string tag, input int f, input logic [7:0][7:0] segs);
      logic [7:0] exp_s;
      logic [7:0] exp_d;
      logic [7:0] one;
      one = 8'h01;
      for (int d = 0; d < 8; d++) begin
         for (int j = 0; j < 8; j++) begin
            wait_to(f + 8 * d + j + 1);
            exp_s = (j < 2) ? 8'hFF : segs[d];
            exp_d = (exp_s == 8'hFF) ? 8'hFF : ~(one << d);
            check($sformatf("%s_seg_d%0d_c%0d", tag, d, j), 32'(abcdefgh), 32'(exp_s));
            check($sformatf("%s_dig_d%0d_c%0d", tag, d, j), 32'(digit), 32'(exp_d));
         end
      end
   endtask

   initial begin
      int acc;
      rst_n           = 1'b0;
      in_if.in_valid  = 1'b0;
      in_if.in_value  = '0;
      in_if.in_dots   = '0;
      in_if.in_enable = '0;
      repeat (3) @(negedge clk);
      check("rst_seg", 32'(abcdefgh), 32'hFF);
      check("rst_dig", 32'(digit), 32'hFF);
      check("rst_ready", 32'(in_if.in_ready), 32'd1);
      check("rst_fs", 32'(frame_start), 32'd0);
      rst_n = 1'b1;

      // Three dark frames, frame_start every 64 cycles.
      for (int k = 1; k <= 192; k++) begin
         @(negedge clk);
         check("idle_seg", 32'(abcdefgh), 32'hFF);
         check("idle_dig", 32'(digit), 32'hFF);
         check("idle_fs", 32'(frame_start), 32'((k % 64) == 0));
      end
      check("idle_ready", 32'(in_if.in_ready), 32'd1);

      // First value: stays dark until the boundary, then shown a whole frame.
      send(32'h0123_89AF, 8'h01, 8'hFF, acc);
      check("acc_first", 32'(acc), 32'd192);
      check("ready_low_first", 32'(in_if.in_ready), 32'd0);
      scan_frame("pre", 192, T_DARK);
      scan_frame("first", 256, T_FIRST);

      // Back-to-back: the second stalls until the cycle after the first commits.
      send(32'h7654_3210, 8'h00, 8'hFF, acc);
      check("acc_a", 32'(acc), 32'd320);
      check("ready_stall", 32'(in_if.in_ready), 32'd0);
      send(32'hC0DE_B0E6, 8'h00, 8'hAA, acc);
      check("acc_b", 32'(acc), 32'd384);
      scan_frame("a", 384, T_A);
      scan_frame("b", 448, T_B);

      // Accept on the boundary tick itself: no bypass, commits a frame later.
      wait_to(575);
      send(32'h0000_0005, 8'h00, 8'h01, acc);
      check("acc_c", 32'(acc), 32'd575);
      scan_frame("c_hold", 576, T_B);
      scan_frame("c", 640, T_C);

      // Leading-zero handling (blanked only when the feature is built in).
      send(32'h0000_0050, 8'h00, 8'hFF, acc);
      check("acc_d", 32'(acc), 32'd704);
      scan_frame("d", 768, T_D);
      send(32'h0000_0000, 8'h00, 8'hFF, acc);
      check("acc_e", 32'(acc), 32'd832);
      scan_frame("e", 896, T_E);
      send(32'h0000_0050, 8'h10, 8'hFF, acc);
      check("acc_f", 32'(acc), 32'd960);
      scan_frame("f", 1024, T_F);

      // Reset mid-frame with data pending: immediate dark, pending dropped.
      send(32'h8888_8888, 8'hFF, 8'hFF, acc);
      check("acc_g", 32'(acc), 32'd1088);
      wait_to(1100);
      rst_n = 1'b0;
      #1;
      check("mid_rst_seg", 32'(abcdefgh), 32'hFF);
      check("mid_rst_dig", 32'(digit), 32'hFF);
      check("mid_rst_ready", 32'(in_if.in_ready), 32'd1);
      check("mid_rst_fs", 32'(frame_start), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      scan_frame("post_rst0", 0, T_DARK);
      check("post_rst_fs", 32'(frame_start), 32'd1);
      scan_frame("post_rst2", 128, T_DARK);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/seg7_scan_controller.md
Name: seg7_scan_controller

Overview:
Time-multiplexed driver for the board's 8-digit common-anode 7-segment display (abcdefgh/digit pins). Accepts a 32-bit hex value, a decimal-point mask and a digit-enable mask through a valid/ready handshake, and double-buffers them so updates commit only at frame boundaries (no tearing). Scans one digit per slot, with an inter-digit blanking gap against ghosting. Sits between user logic and the top-level display pins.

Parameters:
N_DIGITS, 8, number of digits scanned; in_value width is 4*N_DIGITS
SCAN_DIV, 50000, clk cycles per digit slot (1 kHz per digit at 50 MHz); must be >= 2
BLANK_CYCLES, 500, cycles at the start of each slot with all digits off; must be < SCAN_DIV

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  new display contents offered
in_ready  output  1  staging buffer free; transfer on in_valid && in_ready
in_value  input  4*N_DIGITS  hex nibbles; nibble i shown on digit i (digit 0 rightmost)
in_dots  input  N_DIGITS  decimal point per digit, 1 = lit
in_enable  input  N_DIGITS  per-digit enable, 0 = digit dark
abcdefgh  output  8  segments, active-low; bit7 = a … bit1 = g, bit0 = h (dp)
digit  output  N_DIGITS  digit selects, active-low, at most one low at a time
frame_start  output  1  one-cycle pulse when the digit index wraps to 0 (commit cycle)

Behaviour:
- Reset (async, rst_n low): div_cnt = 0, idx = 0, staging/display value, dots and enable = 0, pending = 0; abcdefgh = 8'hFF, digit = all 1s, in_ready = 1, frame_start = 0. Display dark until the first commit.
- div_cnt counts 0..SCAN_DIV-1 and wraps; tick = (div_cnt == SCAN_DIV-1).
- On tick: idx <= (idx == N_DIGITS-1) ? 0 : idx+1. The wrap from N_DIGITS-1 to 0 is the frame boundary.
- Handshake: in_ready = !pending. On accept, in_* are latched into staging and pending <= 1. in_valid without in_ready is ignored; the producer holds its data.
- Commit: on the frame-boundary tick with pending = 1, staging is copied to the display registers and pending <= 0. in_ready rises the next cycle.
- Accept and boundary in the same cycle (pending was 0): the data enters staging and commits at the next boundary. It never bypasses to display.
- Worst-case latency from accept to visible: N_DIGITS*SCAN_DIV + BLANK_CYCLES + 1 cycles.
- frame_start is registered and pulses in the cycle after the boundary tick (idx == 0 cycle 0), whether or not a commit occurred.
- Outputs are registered, one cycle behind idx/div_cnt:
  - digit[idx] = 0 only when div_cnt >= BLANK_CYCLES and display enable[idx] = 1. All other bits = 1.
  - abcdefgh = {decode(nibble[idx]), ~dots[idx]} while that digit is on, else 8'hFF.
- Hex decode (active-low abcdefg): 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000.
- Reset mid-frame: immediate dark; pending data is discarded.

Optional Feature:
SEG7_LEADING_ZERO_BLANK_EN
- Defined: at commit, digits above the most-significant nonzero nibble get their effective enable forced to 0. Digit 0 is never blanked, so value 0 shows a single "0". A lit dot on a digit keeps that digit and all lower digits shown.
- Undefined: the effective enable is exactly the committed in_enable.

Decomposition:
- Shared package/include: segment encoding constants (SEG_BLANK = 8'hFF, the 16 hex patterns) and the segment bit-order definition, reused by other display clients.
- Sub-module seg7_hex_decode: combinational nibble to 7-bit active-low pattern, instantiated once on the muxed nibble.

Test Plan:
(Bench uses SCAN_DIV=8, BLANK_CYCLES=2.)
- Reset release, no input -> digit = 8'hFF, abcdefgh = 8'hFF for 3 full frames; in_ready = 1; frame_start pulses every 64 cycles.
- Accept in_value=32'h0123_89AF, dots=8'h01, enable=8'hFF -> after the next boundary, slot 0 shows abcdefgh=8'h70 (F with dp) and digit=8'hFE for slot cycles 2..7; slot 7 shows 8'h03.
- Two back-to-back valids -> second stalls (in_ready=0) until the cycle after commit; then it is accepted and shown one frame later.
- enable=8'b1010_1010 -> digit never goes low for even digits; abcdefgh=8'hFF in those slots.
- Accept coinciding with the boundary tick -> display unchanged that frame; commits at the following boundary.
- With SEG7_LEADING_ZERO_BLANK_EN, value 32'h0000_0050, dots 0 -> only digits 0 and 1 lit; value 0 -> only digit 0 lit showing 8'h03.
